// File: rtl/conv_window_ctrl.sv
// Load/scan sequencer for a 16x16x8 feature-map buffer with one always-on write
// port and nine registered read ports; presents one 3x3 window per issue.
module conv_window_ctrl #(
  parameter int width    = 16,
  parameter int height   = 16,
  parameter int width_b  = 4,
  parameter int height_b = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [width_b-1:0]  cfg_w,
  input  logic [height_b-1:0] cfg_h,
  input  logic                cfg_stride,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                win_valid,
  output logic [width_b-1:0]  win_x,
  output logic [height_b-1:0] win_y,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [width_b-1:0]  write_w,
  output logic [height_b-1:0] write_h,
  output logic [7:0]          write,
  output logic [width_b-1:0]  read_w0,
  output logic [width_b-1:0]  read_w1,
  output logic [width_b-1:0]  read_w2,
  output logic [width_b-1:0]  read_w3,
  output logic [width_b-1:0]  read_w4,
  output logic [width_b-1:0]  read_w5,
  output logic [width_b-1:0]  read_w6,
  output logic [width_b-1:0]  read_w7,
  output logic [width_b-1:0]  read_w8,
  output logic [height_b-1:0] read_h0,
  output logic [height_b-1:0] read_h1,
  output logic [height_b-1:0] read_h2,
  output logic [height_b-1:0] read_h3,
  output logic [height_b-1:0] read_h4,
  output logic [height_b-1:0] read_h5,
  output logic [height_b-1:0] read_h6,
  output logic [height_b-1:0] read_h7,
  output logic [height_b-1:0] read_h8
);

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  localparam logic [width_b-1:0]  min_w = 2;
  localparam logic [height_b-1:0] min_h = 2;
  localparam logic [width_b:0]    two_w = 2;
  localparam logic [height_b:0]   two_h = 2;
  localparam logic [width_b:0]    cols  = width[width_b:0];
  localparam logic [height_b:0]   rows  = height[height_b:0];

  state_t              state;
  logic [width_b-1:0]  lim_w, col, x;
  logic [height_b-1:0] lim_h, row, y;
  logic                stride2;
  logic [width_b-1:0]  rd_w [9];
  logic [height_b-1:0] rd_h [9];

  logic                cfg_ok;
  logic [width_b:0]    step_w, nx;
  logic [height_b:0]   step_h, ny;
  logic                wrap_x, last_win;
  logic [width_b-1:0]  nxt_x;
  logic [height_b-1:0] nxt_y;

  // Origin arithmetic is one bit wider than the address so x+s+2 cannot wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    nxt_x    = '0;
    nxt_y    = '0;
    cfg_ok   = (cfg_w >= min_w) && (cfg_h >= min_h) &&
               ({1'b0, cfg_w} < cols) && ({1'b0, cfg_h} < rows);
    step_w   = {{(width_b-1){1'b0}}, stride2, ~stride2};
    step_h   = {{(height_b-1){1'b0}}, stride2, ~stride2};
    nx       = {1'b0, x} + step_w;
    ny       = {1'b0, y} + step_h;
    wrap_x   = (nx + two_w) > {1'b0, lim_w};
    last_win = wrap_x && ((ny + two_h) > {1'b0, lim_h});
    if (state == SCAN) begin
      nxt_x = wrap_x ? '0 : nx[width_b-1:0];
      nxt_y = wrap_x ? ny[height_b-1:0] : y;
    end
  end

  // Read addresses are always rebuilt from the origin about to be presented;
  // in LOAD that origin is (0,0), in SCAN it is the advanced one.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state     <= IDLE;
      lim_w     <= '0;
      lim_h     <= '0;
      stride2   <= 1'b0;
      col       <= '0;
      row       <= '0;
      x         <= '0;
      y         <= '0;
      in_ready  <= 1'b0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      write_w   <= '0;
      write_h   <= '0;
      write     <= '0;
      for (int k = 0; k < 9; k++) begin
        rd_w[k] <= '0;
        rd_h[k] <= '0;
      end
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!cfg_ok) begin
              cfg_err <= 1'b1;
            end else begin
              lim_w    <= cfg_w;
              lim_h    <= cfg_h;
              stride2  <= cfg_stride;
              col      <= '0;
              row      <= '0;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
        end

        LOAD: begin
          if (in_valid) begin
            write_w <= col;
            write_h <= row;
            write   <= in_data;
            if (col == lim_w) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (col == lim_w && row == lim_h) begin
              in_ready <= 1'b0;
              x        <= '0;
              y        <= '0;
              state    <= SCAN;
              for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                  rd_w[3*r+c] <= nxt_x + width_b'(c);
                  rd_h[3*r+c] <= nxt_y + height_b'(r);
                end
            end
          end
        end

        SCAN: begin
          if (out_ready) begin
            win_valid <= 1'b1;
            win_x     <= x;
            win_y     <= y;
            if (last_win) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              x <= nxt_x;
              y <= nxt_y;
              for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                  rd_w[3*r+c] <= nxt_x + width_b'(c);
                  rd_h[3*r+c] <= nxt_y + height_b'(r);
                end
            end
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign read_w0 = rd_w[0];
  assign read_w1 = rd_w[1];
  assign read_w2 = rd_w[2];
  assign read_w3 = rd_w[3];
  assign read_w4 = rd_w[4];
  assign read_w5 = rd_w[5];
  assign read_w6 = rd_w[6];
  assign read_w7 = rd_w[7];
  assign read_w8 = rd_w[8];
  assign read_h0 = rd_h[0];
  assign read_h1 = rd_h[1];
  assign read_h2 = rd_h[2];
  assign read_h3 = rd_h[3];
  assign read_h4 = rd_h[4];
  assign read_h5 = rd_h[5];
  assign read_h6 = rd_h[6];
  assign read_h7 = rd_h[7];
  assign read_h8 = rd_h[8];

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: behavioural 16x16 buffer, expected raster window
// list and pixel image kept here; randomized valid/ready traffic.
module tb_conv_window_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_w = '0, cfg_h = '0;
  logic       cfg_stride = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b0;
  logic       in_ready, win_valid, busy, done, cfg_err;
  logic [3:0] win_x, win_y, write_w, write_h;
  logic [7:0] write;
  logic [3:0] read_w0, read_w1, read_w2, read_w3, read_w4, read_w5, read_w6, read_w7, read_w8;
  logic [3:0] read_h0, read_h1, read_h2, read_h3, read_h4, read_h5, read_h6, read_h7, read_h8;
  logic [3:0] rw [9];
  logic [3:0] rh [9];

  conv_window_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_stride(cfg_stride), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .win_valid(win_valid),
    .win_x(win_x), .win_y(win_y), .busy(busy), .done(done), .cfg_err(cfg_err),
    .write_w(write_w), .write_h(write_h), .write(write),
    .read_w0(read_w0), .read_w1(read_w1), .read_w2(read_w2), .read_w3(read_w3),
    .read_w4(read_w4), .read_w5(read_w5), .read_w6(read_w6), .read_w7(read_w7),
    .read_w8(read_w8),
    .read_h0(read_h0), .read_h1(read_h1), .read_h2(read_h2), .read_h3(read_h3),
    .read_h4(read_h4), .read_h5(read_h5), .read_h6(read_h6), .read_h7(read_h7),
    .read_h8(read_h8)
  );

  always #5 clk = ~clk;

  assign rw[0] = read_w0; assign rw[1] = read_w1; assign rw[2] = read_w2;
  assign rw[3] = read_w3; assign rw[4] = read_w4; assign rw[5] = read_w5;
  assign rw[6] = read_w6; assign rw[7] = read_w7; assign rw[8] = read_w8;
  assign rh[0] = read_h0; assign rh[1] = read_h1; assign rh[2] = read_h2;
  assign rh[3] = read_h3; assign rh[4] = read_h4; assign rh[5] = read_h5;
  assign rh[6] = read_h6; assign rh[7] = read_h7; assign rh[8] = read_h8;

  // Feature-map buffer: writes every cycle, nine registered read ports, no reset.
  logic [7:0] mem [16][16];
  logic [7:0] rd [9];
  always @(posedge clk) begin
    mem[write_h][write_w] <= write;
    for (int k = 0; k < 9; k++) rd[k] <= mem[rh[k]][rw[k]];
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference job description
  logic [7:0] img [16][16];
  int         qx[$], qy[$];
  int         cw = 0, ch = 0, exp_n = 0, pix_ptr = 0, nwin = 0, ndone = 0, cyc = 0;
  int         gap_pct = 0, or_mode = 0;
  bit         chk_en = 0, go_start = 0, poke_start = 0;
  logic [3:0] st_w = '0, st_h = '0;
  logic       st_s = 1'b0;

  // Snapshot of the previous cycle as seen at its falling edge
  logic        p_acc = 0, p_stall = 0, p_start_busy = 0;
  logic [3:0]  p_ww = '0, p_wh = '0;
  logic [7:0]  p_wr = '0;
  logic [71:0] p_addr = '0;
  logic        o_cfg_err = 0, o_busy = 0;

  function automatic logic [71:0] addr_vec();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) begin
      v[8*k +: 4]   = rw[k];
      v[8*k+4 +: 4] = rh[k];
    end
    return v;
  endfunction

  function automatic logic [127:0] out_vec();
    return {27'd0, in_ready, win_valid, win_x, win_y, busy, done, cfg_err,
            write_w, write_h, write, addr_vec()};
  endfunction

  // One clock: check what the last rising edge produced, then drive the next inputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    o_cfg_err = cfg_err;
    o_busy    = busy;
    if (chk_en) begin
      if (p_acc) begin
        int c = pix_ptr % (cw + 1);
        int r = pix_ptr / (cw + 1);
        check("wr_addr", {write_h, write_w}, {r[3:0], c[3:0]});
        check("wr_data", write, img[r][c]);
        pix_ptr++;
      end else begin
        check("wr_hold", {write_h, write_w, write}, {p_wh, p_ww, p_wr});
      end
      if (p_stall) begin
        check("stall_valid", win_valid, 1'b0);
        check("stall_addr", addr_vec(), p_addr);
      end
      if (p_start_busy) check("start_ignored", cfg_err, 1'b0);
      if (win_valid) begin
        if (qx.size() == 0) begin
          check("extra_win", win_valid, 1'b0);
        end else begin
          int ex = qx.pop_front();
          int ey = qy.pop_front();
          nwin++;
          check("win_xy", {win_y, win_x}, {ey[3:0], ex[3:0]});
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              check("win_pix", rd[3*r+c], img[ey+r][ex+c]);
          check("done_align", done, qx.size() == 0);
          check("busy_at_win", busy, qx.size() != 0);
        end
      end else begin
        check("done_idle", done, 1'b0);
      end
      if (done) ndone++;
    end

    start      = go_start;
    cfg_w      = st_w;
    cfg_h      = st_h;
    cfg_stride = st_s;
    if (poke_start && busy && $urandom_range(15) == 0) begin
      start = 1'b1;
      cfg_w = 4'($urandom);
      cfg_h = 4'($urandom);
    end
    in_valid = ($urandom_range(99) >= gap_pct);
    if (pix_ptr < (cw + 1) * (ch + 1)) in_data = img[pix_ptr / (cw + 1)][pix_ptr % (cw + 1)];
    else in_data = 8'($urandom);
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((cyc / 3) % 2) == 0;
      default: out_ready = 1'($urandom);
    endcase

    p_acc        = in_valid && in_ready;
    p_stall      = busy && !in_ready && !out_ready;
    p_start_busy = start && busy;
    p_ww         = write_w;
    p_wh         = write_h;
    p_wr         = write;
    p_addr       = addr_vec();
  endtask

  task automatic prep_job(input int w, input int h, input int s, input int gap,
                          input int orm, input bit pattern, input bit poke);
    cw = w; ch = h; gap_pct = gap; or_mode = orm; poke_start = poke;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = pattern ? 8'((r * 16 + c) & 8'hFF) : 8'($urandom);
    qx.delete();
    qy.delete();
    for (int yy = 0; yy + 2 <= h; yy += s)
      for (int xx = 0; xx + 2 <= w; xx += s) begin
        qx.push_back(xx);
        qy.push_back(yy);
      end
    exp_n = qx.size(); pix_ptr = 0; nwin = 0; ndone = 0;
    st_w = 4'(w); st_h = 4'(h); st_s = (s == 2);
    go_start = 1;
    tick();
    go_start = 0;
  endtask

  task automatic run_job(input int w, input int h, input int s, input int gap,
                         input int orm, input bit pattern, input bit poke);
    prep_job(w, h, s, gap, orm, pattern, poke);
    for (int i = 0; i < 5000 && ndone == 0; i++) tick();
    poke_start = 0;
    tick();
    tick();
    check("win_count", nwin, exp_n);
    check("done_count", ndone, 1);
    check("busy_end", busy, 1'b0);
    check("pix_count", pix_ptr, (w + 1) * (h + 1));
  endtask

  task automatic bad_cfg(input int w, input int h);
    st_w = 4'(w); st_h = 4'(h);
    go_start = 1;
    tick();
    go_start = 0;
    tick();
    check("cfg_err_pulse", o_cfg_err, 1'b1);
    check("cfg_err_busy", o_busy, 1'b0);
    tick();
    check("cfg_err_clear", o_cfg_err, 1'b0);
    check("cfg_err_idle", busy, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset_outs", out_vec(), '0);
    reset = 1'b0;
    tick();
    chk_en = 1;

    run_job(15, 15, 1, 0, 0, 1, 0);   // full frame, 196 windows
    run_job(4, 4, 2, 0, 0, 0, 0);     // 4 windows
    run_job(3, 3, 2, 0, 0, 0, 0);     // 1 window
    run_job(15, 15, 1, 40, 0, 1, 0);  // input gaps
    run_job(15, 15, 1, 0, 1, 1, 1);   // stalls + stray starts

    bad_cfg(1, 5);
    bad_cfg(7, 1);

    // Abort mid-scan, then a clean job
    prep_job(15, 15, 1, 0, 2, 0, 0);
    for (int i = 0; i < 2000 && nwin < 10; i++) tick();
    check("reached_scan", nwin >= 10, 1'b1);
    chk_en = 0;
    reset  = 1'b1;
    tick();
    check("reset_mid_scan", out_vec(), '0);
    tick();
    check("reset_hold", out_vec(), '0);
    reset = 1'b0;
    tick();
    chk_en = 1;
    run_job(15, 15, 1, 10, 0, 1, 0);

    for (int j = 0; j < 4; j++)
      run_job($urandom_range(3, 15), $urandom_range(3, 15), $urandom_range(1, 2),
              $urandom_range(0, 50), 2, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Sequencer for the 16x16x8-bit feature-map buffer (`memory_part`: 1 write port, 9 registered read ports).
- Two phases:
  - LOAD: accepts a raster pixel stream and drives the buffer's write port.
  - SCAN: drives all nine read addresses so the buffer outputs one 3x3 window per issue, for the downstream MAC array.
- Handles image size, stride, throttling and the buffer's always-on write port.

Parameters:
- width, 16, buffer columns
- height, 16, buffer rows
- width_b, 4, column address bits
- height_b, 4, row address bits

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_*, begins LOAD
- cfg_w  in  width_b  last column index (image width - 1)
- cfg_h  in  height_b  last row index (image height - 1)
- cfg_stride  in  1  0: stride 1, 1: stride 2
- in_valid  in  1  pixel present
- in_data  in  8  pixel value
- in_ready  out  1  controller accepts pixel
- out_ready  in  1  downstream permits next window issue
- win_valid  out  1  buffer read outputs hold a new window this cycle
- win_x  out  width_b  window origin column, aligned with win_valid
- win_y  out  height_b  window origin row, aligned with win_valid
- busy  out  1  LOAD or SCAN active
- done  out  1  one-cycle pulse, aligned with the last win_valid
- cfg_err  out  1  one-cycle pulse, start rejected
- write_w  out  width_b  buffer write column
- write_h  out  height_b  buffer write row
- write  out  8  buffer write data
- read_w0..read_w8  out  width_b each  buffer read columns
- read_h0..read_h8  out  height_b each  buffer read rows

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Reset asserted mid-LOAD or mid-SCAN aborts immediately: no done pulse, buffer contents left as-is.
- Write port rule (the buffer writes every cycle):
  - Outside an accepted pixel cycle, write_w, write_h and write hold the last written address and data, so the buffer rewrites identical data.
  - After reset this is (0,0,0).
- States:
  - IDLE:
    - start with cfg_w<2 or cfg_h<2 -> cfg_err=1 next cycle, stay IDLE.
    - Otherwise latch cfg, clear the column/row counters, go LOAD.
  - LOAD:
    - in_ready=1.
    - On in_valid: drive write_w=col, write_h=row, write=in_data (registered, visible next cycle); col increments.
    - At col==cfg_w: col wraps to 0 and row increments.
    - On the pixel at (cfg_w,cfg_h): go SCAN with origin x=y=0.
    - start is ignored in LOAD and SCAN.
  - SCAN:
    - in_ready=0.
    - Read port k (k=3r+c, r,c in 0..2) is driven as read_w_k = x+c, read_h_k = y+r, registered from the origin.
    - A window is issued in a cycle where the addresses are presented and out_ready=1.
    - Issued window: win_valid=1 one cycle later, matching the buffer's 1-cycle read latency. win_x/win_y carry that window's origin.
    - While out_ready=0: addresses are held and nothing is issued.
    - Advance after an issue, step s = 1 or 2:
      - nx = x+s.
      - If nx+2 > cfg_w: x=0, ny = y+s.
      - If ny+2 > cfg_h: the issue was the last one; go DONE.
      - Compare in width_b+1 bits so there is no wrap.
  - DONE:
    - One cycle: done=1 together with the last win_valid.
    - Then IDLE; busy=0 from the DONE cycle onward.
- Window count = (floor((cfg_w-2)/s)+1) * (floor((cfg_h-2)/s)+1). Each window is issued exactly once, in raster order.
- Downstream must sample the window whenever win_valid=1; there is no backpressure on issued data.

Test Plan:
1. cfg_w=cfg_h=15, stride 1, 256 pixels with value (row*16+col)&0xFF, out_ready=1:
   - Expect exactly 196 win_valid pulses.
   - First window origin (0,0), read0=0x00, read4=0x11, read8=0x22.
   - Last window origin (13,13).
   - done coincident with the last win_valid.
2. cfg_w=cfg_h=4, stride 2:
   - Expect 4 windows, origins (0,0), (2,0), (0,2), (2,2).
   - cfg_w=3 with stride 2 -> 1 window.
3. Random in_valid gaps during LOAD:
   - Write port holds its last address and data during each gap.
   - Buffer readback shows no corrupted pixel.
4. out_ready toggled 0/1 every 3 cycles during SCAN:
   - No duplicate or skipped origins.
   - Addresses stable while stalled.
   - Window count unchanged (196).
5. start with cfg_w=1 -> cfg_err pulse, busy stays 0. start during SCAN -> ignored.
6. reset asserted mid-SCAN:
   - Next cycle all outputs 0, no done pulse.
   - A new start then runs a full correct job.
